// File: rtl/cv32e40px_rf_wb_queue.sv
// ============================================================================
// Module  : cv32e40px_rf_wb_queue
// Brief   : Coprocessor result queue feeding register-file write port B.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40px_rf_wb_queue #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int X_DUALWRITE = 0,
  parameter int DEPTH       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 x_result_valid_i,
  output logic                                 x_result_ready_o,
  input  logic [ADDR_WIDTH-1:0]                x_result_rd_i,
  input  logic [2*DATA_WIDTH-1:0]              x_result_data_i,
  input  logic [1:0]                           x_result_we_i,
  input  logic                                 lsu_wb_busy_i,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [(X_DUALWRITE+1)*DATA_WIDTH-1:0] wdata_b_o,
  output logic [X_DUALWRITE:0]                 we_b_o,
  input  logic [ADDR_WIDTH-1:0]                chk_addr_i,
  output logic                                 chk_hit_o,
  output logic                                 pending_o
);

  localparam int                    PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]        CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]        CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {P0 = 1'b0, P1 = 1'b1} phase_e;

  logic [ADDR_WIDTH-1:0]   rd_q   [DEPTH];
  logic [2*DATA_WIDTH-1:0] data_q [DEPTH];
  logic [1:0]              we_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  phase_e           phase_q, phase_d;

  logic                    ready;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [1:0]              push_we;
  logic [ADDR_WIDTH-1:0]   head_rd;
  logic [ADDR_WIDTH-1:0]   head_rd1;
  logic [2*DATA_WIDTH-1:0] head_data;
  logic [1:0]              head_we;
  logic [PTR_W-1:0]        chk_off;
  logic                    chk_hit;

  // Ready depends only on occupancy, so it never sees a same-cycle pop.
  assign ready            = !rst && (count_q < CNT_DEPTH);
  assign x_result_ready_o = ready;
  assign push             = x_result_valid_i && ready;
  // An odd rd has no partner register, so its upper-half enable is dropped.
  assign push_we          = {x_result_we_i[1] & ~x_result_rd_i[0], x_result_we_i[0]};

  assign head_rd   = rd_q[rd_ptr_q];
  assign head_rd1  = head_rd + ADDR_ONE;
  assign head_data = data_q[rd_ptr_q];
  assign head_we   = we_q[rd_ptr_q];
  assign issue     = (count_q != '0) && !lsu_wb_busy_i;
  assign pending_o = (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= x_result_rd_i;
      data_q[wr_ptr_q] <= x_result_data_i;
      we_q[wr_ptr_q]   <= push_we;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= P0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
    end
  end

  generate
    if (X_DUALWRITE != 0) begin : g_dual
      always_comb begin
        waddr_b_o = head_rd;
        wdata_b_o = head_data;
        we_b_o    = '0;
        pop       = 1'b0;
        phase_d   = P0;
        if (issue) begin
          we_b_o = {head_we[1], head_we[0] & (head_rd != '0)};
          pop    = 1'b1;
        end
      end
    end else begin : g_split
      logic wen;
      always_comb begin
        waddr_b_o = head_rd;
        wdata_b_o = head_data[DATA_WIDTH-1:0];
        wen       = 1'b0;
        pop       = 1'b0;
        phase_d   = phase_q;
        if (issue) begin
          if (phase_q == P1) begin
            waddr_b_o = head_rd1;
            wdata_b_o = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
            wen       = 1'b1;
            pop       = 1'b1;
            phase_d   = P0;
          end else begin
            unique case (head_we)
              2'b01: begin
                wen = 1'b1;
                pop = 1'b1;
              end
              2'b10: begin
                waddr_b_o = head_rd1;
                wdata_b_o = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
                wen       = 1'b1;
                pop       = 1'b1;
              end
              2'b11: begin
                wen     = 1'b1;
                phase_d = P1;
              end
              default: pop = 1'b1;
            endcase
          end
        end
        // Register 0 is hard-wired; its write is dropped but sequencing is kept.
        we_b_o = wen && (waddr_b_o != '0);
      end
    end
  endgenerate

  always_comb begin
    chk_hit = 1'b0;
    chk_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_off = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, chk_off} < count_q) begin
        if (we_q[i][0] && (rd_q[i] == chk_addr_i) &&
            !((chk_off == '0) && (phase_q == P1)))
          chk_hit = 1'b1;
        if (we_q[i][1] && ((rd_q[i] + ADDR_ONE) == chk_addr_i))
          chk_hit = 1'b1;
      end
    end
  end

  assign chk_hit_o = chk_hit;

endmodule

`default_nettype wire

// File: doc/cv32e40px_rf_wb_queue.md
CV32E40PX_RF_WB_QUEUE -- requirements
Module: cv32e40px_rf_wb_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register-file address width (bit 5 selects the FP bank).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one register word.
REQ-003 SHALL have parameter X_DUALWRITE, default 0; 1 means the register file accepts a pair write in one cycle.
REQ-004 SHALL have parameter DEPTH, default 2, number of queue entries (power of two, at least 2).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have port x_result_valid_i, input, 1 bit, coprocessor result valid.
REQ-008 SHALL have port x_result_ready_o, output, 1 bit, queue can accept a result.
REQ-009 SHALL have port x_result_rd_i, input, ADDR_WIDTH bits, destination register.
REQ-010 SHALL have port x_result_data_i, input, 2*DATA_WIDTH bits; [DATA_WIDTH-1:0] goes to rd and the upper half to rd+1.
REQ-011 SHALL have port x_result_we_i, input, 2 bits; bit0 writes rd, bit1 writes rd+1.
REQ-012 SHALL have port lsu_wb_busy_i, input, 1 bit; the LSU owns write port B this cycle and has priority.
REQ-013 SHALL have port waddr_b_o, output, ADDR_WIDTH bits, the register-file port-B address.
REQ-014 SHALL have port wdata_b_o, output, (X_DUALWRITE+1)*DATA_WIDTH bits, the port-B data.
REQ-015 SHALL have port we_b_o, output, X_DUALWRITE+1 bits, the port-B write enables.
REQ-016 SHALL have port chk_addr_i, input, ADDR_WIDTH bits, the scoreboard query address.
REQ-017 SHALL have port chk_hit_o, output, 1 bit; a queued write to chk_addr_i is pending.
REQ-018 SHALL have port pending_o, output, 1 bit; the queue is not empty.

Function
REQ-019 SHALL drive x_result_ready_o = (count < DEPTH), with no dependence on a same-cycle pop and no combinational path from the valid input.
REQ-020 SHALL push {rd, data, we} into the FIFO tail on valid&&ready; it SHALL never push when full.
REQ-021 SHALL drive the outputs combinationally from the FIFO head; an accepted result is written no earlier than the cycle after acceptance.
REQ-022 SHALL treat we bit1 as 0 on push when rd[0]=1 (odd rd has no pair).
REQ-023 SHALL hold we_b_o at all-zero while the queue is empty or lsu_wb_busy_i=1; in those cycles the head and phase SHALL not change.
REQ-024 With X_DUALWRITE=1 and the head issued, SHALL drive waddr_b_o=rd, wdata_b_o=data, we_b_o=we, and pop the head in one cycle.
REQ-025 With X_DUALWRITE=0, SHALL run a phase FSM with states P0 and P1; reset state is P0.
REQ-026 FSM P0 with head we=01: SHALL write rd with the low half, pop, and stay in P0.
REQ-027 FSM P0 with head we=10: SHALL write rd+1 with the high half, pop, and stay in P0.
REQ-028 FSM P0 with head we=11: SHALL write rd with the low half, not pop, and go to P1.
REQ-029 FSM P1: SHALL write rd+1 with the high half, pop, and go to P0.
REQ-030 FSM stall: lsu_wb_busy_i SHALL freeze the state in either phase.
REQ-031 SHALL pop a head with we=00 in one non-stalled cycle without asserting we_b_o.
REQ-032 SHALL suppress any write to address 0 (its enable forced to 0); the pop and phase sequence SHALL proceed unchanged.
REQ-033 Simultaneous push and pop SHALL both take effect; count is unchanged and the pointers wrap modulo DEPTH.
REQ-034 SHALL assert chk_hit_o when any valid entry has (we[0] && rd==chk_addr_i) or (we[1] && rd+1==chk_addr_i).
REQ-035 SHALL exclude the already-written rd half of the head from chk_hit_o while in P1.
REQ-036 SHALL assert pending_o = (count != 0).

Reset
REQ-037 While rst=1, the block SHALL clear count and both pointers, set the FSM to P0, drive x_result_ready_o=0 and we_b_o=0, and drive chk_hit_o=0 and pending_o=0.
REQ-038 Assertion of rst mid-operation, including in P1, SHALL discard all entries; no write SHALL be issued until a new push.
REQ-039 After rst deasserts, x_result_ready_o SHALL be 1 in the first cycle.

Verification
REQ-040 Single write: push rd=5, data low=0xA5A5A5A5, we=01 -> next cycle waddr_b_o=5, we_b_o=1, wdata=0xA5A5A5A5; pending_o=0 the cycle after.
REQ-041 Split pair (X_DUALWRITE=0): push rd=8, we=11, low=0x11, high=0x22 -> writes r8=0x11 then r9=0x22 on consecutive cycles; chk r8 hit=0 and r9 hit=1 during P1.
REQ-042 Stall: lsu_wb_busy_i=1 for 3 cycles with the queue holding rd=3 -> we_b_o=0 for 3 cycles, then r3 is written on the 4th cycle.
REQ-043 Full: DEPTH=2, two pushes while stalled -> x_result_ready_o=0; third valid is held; on release ready returns the cycle after the first pop.
REQ-044 Odd/zero address: push rd=7 we=11 -> only r7 is written; push rd=0 we=01 -> no write, entry popped in 1 cycle.
REQ-045 Reset in P1: assert rst after the first half of rd=10 we=11 -> r11 is never written; count=0 and ready=1 after release.
